// File: rtl/dbg_loader_pkg.sv
// Shared types for the debug/load controller: command opcodes, FSM states, default width.
package dbg_loader_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WR_IMEM  = 3'd1,
    OP_WR_DMEM  = 3'd2,
    OP_RD_REG   = 3'd3,
    OP_RUN      = 3'd4,
    OP_CORE_RST = 3'd5,
    OP_DUMP     = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_RUN  = 3'd2,
    S_DUMP = 3'd3,
    S_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/dbg_loader_if.sv
// Host command/response channel of dbg_loader; master = host side, slave = loader.
interface dbg_loader_if #(
  parameter int XLEN = dbg_loader_pkg::XLEN_DEF
);
  // Both channels: a transfer occurs on a rising edge with valid && ready; the sender
  // holds valid and payload stable until that edge and never waits on ready to raise valid.
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [15:0]     cmd_addr;
  logic [XLEN-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );
endinterface

// File: rtl/dbg_run_timer.sv
// Loadable down-counter: en is high while the count is non-zero, done pulses once it expires.
module dbg_run_timer #(
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [CYCLE_W-1:0] load_val,
  output logic               en,
  output logic               done
);

  logic [CYCLE_W-1:0] cnt;

  // A zero load still yields a done pulse so the caller never waits forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - CYCLE_W'(1);
      done <= (cnt == CYCLE_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign en = (cnt != '0);

endmodule

// File: rtl/dbg_loader.sv
// Debug/load controller for the single-cycle core: memory preload, bounded RUN, register readback.
// Define DBG_LOADER_DUMP_EN to enable the streaming register DUMP command.
module dbg_loader
  import dbg_loader_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int NREGS      = 32,
  parameter int CYCLE_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  dbg_loader_if.slave                   bus,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [XLEN-1:0]               imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  output logic [XLEN-1:0]               dmem_wdata,
  output logic [4:0]                    reg_raddr,
  input  logic [XLEN-1:0]               reg_rdata,
  input  logic [XLEN-1:0]               core_pc,
  output logic                          core_rst,
  output logic                          core_en,
  output state_e                        dbg_state
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [15:0] IMEM_LIM = 16'(IMEM_DEPTH);
  localparam logic [15:0] DMEM_LIM = 16'(DMEM_DEPTH);
  localparam logic [15:0] NREG_LIM = 16'(NREGS);
`ifdef DBG_LOADER_DUMP_EN
  localparam logic [4:0] LAST_REG = 5'(NREGS - 1);
`endif

  state_e      state;
  op_e         op_q;
  op_e         op_in;
  logic [15:0] addr_q;
  logic        accept;
  logic        run_done;

  assign op_in     = op_e'(bus.cmd_op);
  assign accept    = (state == S_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign dbg_state = state;

  dbg_run_timer #(.CYCLE_W(CYCLE_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept && (op_in == OP_RUN)),
    .load_val (bus.cmd_data[CYCLE_W-1:0]),
    .en       (core_en),
    .done     (run_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      op_q          <= OP_NOP;
      addr_q        <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_last  <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      reg_raddr     <= '0;
      core_rst      <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.cmd_ready <= 1'b0;
            op_q          <= op_in;
            addr_q        <= bus.cmd_addr;
            state         <= S_EXEC;
            // Side effects are launched here so they are visible during the EXEC cycle.
            case (op_in)
              OP_WR_IMEM: begin
                imem_we    <= (bus.cmd_addr < IMEM_LIM);
                imem_addr  <= bus.cmd_addr[IAW-1:0];
                imem_wdata <= bus.cmd_data;
              end
              OP_WR_DMEM: begin
                dmem_we    <= (bus.cmd_addr < DMEM_LIM);
                dmem_addr  <= bus.cmd_addr[DAW-1:0];
                dmem_wdata <= bus.cmd_data;
              end
              OP_RD_REG:   reg_raddr <= bus.cmd_addr[4:0];
              OP_CORE_RST: core_rst  <= 1'b1;
              OP_RUN: begin
                core_rst <= 1'b0;
                state    <= S_RUN;
              end
`ifdef DBG_LOADER_DUMP_EN
              OP_DUMP: begin
                reg_raddr <= '0;
                state     <= S_DUMP;
              end
`endif
              default: ;
            endcase
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        S_EXEC: begin
          state         <= S_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_last  <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= '0;
          case (op_q)
            OP_WR_IMEM: begin
              bus.rsp_data <= XLEN'(addr_q);
              bus.rsp_err  <= (addr_q >= IMEM_LIM);
            end
            OP_WR_DMEM: begin
              bus.rsp_data <= XLEN'(addr_q);
              bus.rsp_err  <= (addr_q >= DMEM_LIM);
            end
            OP_RD_REG: begin
              if (addr_q >= NREG_LIM) bus.rsp_err  <= 1'b1;
              else                    bus.rsp_data <= reg_rdata;
            end
            OP_CORE_RST: core_rst <= 1'b0;
            OP_NOP:      ;
            default:     bus.rsp_err <= 1'b1;
          endcase
        end
        S_RUN: begin
          // done arrives in the first cycle with core_en low, so core_pc is settled.
          if (run_done) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_last  <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= core_pc;
          end
        end
`ifdef DBG_LOADER_DUMP_EN
        S_DUMP: begin
          state         <= S_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_last  <= (reg_raddr == LAST_REG);
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= reg_rdata;
        end
`endif
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= S_IDLE;
`ifdef DBG_LOADER_DUMP_EN
            if (op_q == OP_DUMP && !bus.rsp_last) begin
              bus.cmd_ready <= 1'b0;
              reg_raddr     <= reg_raddr + 5'd1;
              state         <= S_DUMP;
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
